smm_sched: RTL and testbench
============================

# smm_sched

Round-robin scheduler that shares one Strassen 2×2 multiply unit (the `load`/`sel` datapath producing `C_out`) among `NREQ` requesters. It accepts jobs over valid/ready handshakes and drives the unit's operand buses and `load`/`sel`. It tracks each job through the unit's fixed two-edge pipeline, returns results with requester ID through a credit-protected response FIFO, and inserts bubbles so `sel` never changes under an in-flight job.

## Interface
- `DATAWIDTH`, 32, element width
- `BUSWIDTH`, 4*DATAWIDTH, packed 2×2 operand/result; block i = bits [(i+1)*DATAWIDTH-1 : i*DATAWIDTH], blocks 0..3 = m00,m01,m10,m11
- `NREQ`, 2, number of requesters (≥2)
- `RSP_DEPTH`, 4, response FIFO depth (power of 2, ≥4)
- `IDW`, $clog2(NREQ), requester ID width
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester job valid
- `req_ready`  out  NREQ  per-requester accept (one-hot or zero)
- `req_mode`  in  NREQ  per-requester mode: 0 = full (sel=0), 1 = partial (sel=1)
- `req_a`, `req_b`  in  NREQ*BUSWIDTH  per-requester operands, requester r at slice r
- `smm_a`, `smm_b`  out  BUSWIDTH  operands to multiply unit
- `smm_load`  out  1  unit load strobe
- `smm_sel`  out  1  unit mode select (registered)
- `smm_c`  in  BUSWIDTH  unit `C_out`
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumer accept
- `rsp_id`  out  IDW  requester that issued the job
- `rsp_data`  out  BUSWIDTH  result, unmodified from `smm_c`

## Operation
- Arbitration: winner is the first `req_valid` bit at or after `rr_ptr`, wrapping. `rr_ptr` advances to winner+1 (mod NREQ) only on issue. Stalls never move it, so a stalled winner keeps priority.
- Issue condition: winner exists, `req_mode[winner] == smm_sel`, and credits are available (`fifo_count + v1 + v2 < RSP_DEPTH`). On issue, in the same cycle: `req_ready[winner]=1`, `smm_load=1`, `smm_a/smm_b` = winner's operands (combinational mux).
- Mode switch: if the winner's mode differs from `smm_sel`, no issue occurs. If `v1==0`, then `smm_sel <= req_mode[winner]` and issue occurs the following cycle at the earliest. If `v1==1`, the scheduler waits.
- `smm_sel` therefore never changes on the edge that captures an in-flight job's `C_out`. Mode-switch penalty is 1 to 2 cycles.
- Pipeline tracking: `v1 <= issue`, `id1 <= winner`; `v2 <= v1`, `id2 <= id1`.
- When `v2==1`, push `{id2, smm_c}` into the FIFO. The push never fails because of the credit rule.
- Requesters must hold `req_valid`, mode and operands stable until `req_ready`. Behaviour is undefined otherwise.
- Partial-mode results pass through as the unit produces them: blocks [3..0] = {C01, 0, C10, 0}.
- FIFO: simultaneous push and pop with `rsp_valid && rsp_ready` is allowed, including when full (credits guarantee no overflow). Pop on empty does nothing.
- Reset: all in-flight jobs (v1/v2) and FIFO contents are dropped with no response. The shared unit is reset by the same `rst`.

## Timing
- Reset values: `req_ready=0`, `smm_load=0`, `smm_sel=0`, `smm_a=smm_b=0` (no winner selects 0), `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rr_ptr=0`, `v1=v2=0`, FIFO empty.
- `smm_load` high in cycle k; the unit captures T/S at the end of cycle k and `C_out` at the end of k+1. `smm_c` is valid in k+2 and pushed at the end of k+2. `rsp_valid` is high from cycle k+3 when the FIFO was empty: latency 3 cycles.
- Throughput: 1 job/cycle in steady state with same mode and `rsp_ready` held high.
- `req_ready` and `smm_load` are combinational from `req_valid`, `req_mode`, `smm_sel`, credits and `v1`. `rsp_*` come from FIFO registers.

## Structure
- Package `smm_pkg`: the `DATAWIDTH`/`BUSWIDTH` defaults, a block-index helper, mode encodings `MODE_FULL=0` and `MODE_PART=1`, and the unit latency constant `SMM_LAT=2`.
- One sub-module: `smm_rsp_fifo`, a synchronous FIFO of width IDW+BUSWIDTH and depth RSP_DEPTH with count output.

## Test plan
- Single full job, A blocks 1,2,3,4 and B blocks 5,6,7,8 from req 0 → `smm_load` in one cycle; three cycles later `rsp_valid=1`, `rsp_id=0`, blocks [3..0] = 50,43,22,19.
- Same operands, mode 1 from req 1 → `smm_sel` goes to 1 with no load that cycle; issue follows; `rsp_data` blocks [3..0] = 22,0,43,0, `rsp_id=1`.
- Both requesters valid continuously, both mode 0 → issues alternate 0,1,0,1 every cycle; responses arrive in issue order with alternating IDs.
- Back-to-back issue of req 0 mode 0 then req 1 mode 1 → two-cycle gap before the second load; the first result still has full-mode content.
- `rsp_ready=0`, RSP_DEPTH=4, continuous requests → exactly 4 issues, then `req_ready=0`. Raising `rsp_ready` drains 4 results and issue resumes; no result is lost or duplicated.
- Assert `rst` one cycle after an issue → no response; all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/smm_pkg.sv
// Shared constants and types for the Strassen 2x2 multiply scheduler.
package smm_pkg;
    localparam int DATAWIDTH = 32;
    localparam int BUSWIDTH  = 4 * DATAWIDTH;
    localparam int SMM_LAT   = 2;

    typedef enum logic {
        MODE_FULL = 1'b0,
        MODE_PART = 1'b1
    } smm_mode_e;

    // Block i of a packed 2x2 matrix starts at bit i*dw (0..3 = m00,m01,m10,m11).
    function automatic int blk_lsb(int blk, int dw);
        return blk * dw;
    endfunction
endpackage

// File: rtl/smm_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; pop on empty is ignored.
module smm_rsp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign valid  = (count != '0);
    assign rdata  = mem[rd_ptr];

    // Storage is cleared too so the read port shows zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/smm_sched.sv
// Round-robin scheduler feeding one shared Strassen 2x2 unit; tracks jobs
// through its two-edge pipeline and returns tagged results via a credited FIFO.
module smm_sched #(
    parameter int DATAWIDTH = smm_pkg::DATAWIDTH,
    parameter int BUSWIDTH  = 4 * DATAWIDTH,
    parameter int NREQ      = 2,
    parameter int RSP_DEPTH = 4,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_mode,
    input  logic [NREQ*BUSWIDTH-1:0] req_a,
    input  logic [NREQ*BUSWIDTH-1:0] req_b,
    output logic [BUSWIDTH-1:0]      smm_a,
    output logic [BUSWIDTH-1:0]      smm_b,
    output logic                     smm_load,
    output logic                     smm_sel,
    input  logic [BUSWIDTH-1:0]      smm_c,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [BUSWIDTH-1:0]      rsp_data
);
    import smm_pkg::*;

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic [IDW-1:0]              rr_ptr;
    logic [IDW-1:0]              win;
    logic                        have_win;
    logic                        mode_ok;
    logic                        credit_ok;
    logic                        issue;
    logic [SMM_LAT:1]            vld_pipe;
    logic [SMM_LAT:1][IDW-1:0]   id_pipe;
    logic [CW-1:0]               fifo_count;
    logic [CW:0]                 used;
    logic [IDW+BUSWIDTH-1:0]     fifo_rdata;
    int                          j;

    always_comb begin
        have_win = 1'b0;
        win      = '0;
        j        = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!have_win && req_valid[IDW'(j)]) begin
                have_win = 1'b1;
                win      = IDW'(j);
            end
        end
    end

    // Every job already issued but not yet popped holds a FIFO slot in reserve.
    assign used      = {1'b0, fifo_count} + (CW+1)'(vld_pipe[1]) + (CW+1)'(vld_pipe[SMM_LAT]);
    assign credit_ok = used < (CW+1)'(RSP_DEPTH);
    assign mode_ok   = req_mode[win] == smm_sel;
    assign issue     = have_win && mode_ok && credit_ok;

    assign req_ready = issue ? (NREQ'(1) << win) : '0;
    assign smm_load  = issue;
    assign smm_a     = have_win ? req_a[win*BUSWIDTH +: BUSWIDTH] : '0;
    assign smm_b     = have_win ? req_b[win*BUSWIDTH +: BUSWIDTH] : '0;

    // sel only moves when nothing sits between load and C_out capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
            smm_sel  <= MODE_FULL;
        end else begin
            vld_pipe <= {vld_pipe[SMM_LAT-1:1], issue};
            id_pipe  <= {id_pipe[SMM_LAT-1:1], win};
            if (issue)
                rr_ptr <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
            else if (have_win && !mode_ok && !vld_pipe[1])
                smm_sel <= req_mode[win];
        end
    end

    smm_rsp_fifo #(
        .W     (IDW + BUSWIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_pipe[SMM_LAT]),
        .wdata ({id_pipe[SMM_LAT], smm_c}),
        .pop   (rsp_ready),
        .rdata (fifo_rdata),
        .valid (rsp_valid),
        .count (fifo_count)
    );

    assign rsp_id   = fifo_rdata[IDW+BUSWIDTH-1 -: IDW];
    assign rsp_data = fifo_rdata[BUSWIDTH-1:0];
endmodule

// File: tb/tb_smm_sched.sv
// Scoreboard bench for smm_sched with a behavioural 2x2 multiply unit model.
module tb_smm_sched;
    import smm_pkg::*;

    localparam int DW = 32, BW = 4*DW, NREQ = 2, RSP_DEPTH = 4, IDW = 1;

    logic                 clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0, req_mode = '0, req_ready;
    logic [NREQ*BW-1:0]   req_a = '0, req_b = '0;
    logic [BW-1:0]        smm_a, smm_b, smm_c, rsp_data;
    logic                 smm_load, smm_sel, rsp_valid, rsp_ready = 1'b1;
    logic [IDW-1:0]       rsp_id;

    always #5 clk = ~clk;

    smm_sched #(.DATAWIDTH(DW), .BUSWIDTH(BW), .NREQ(NREQ), .RSP_DEPTH(RSP_DEPTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b), .smm_a(smm_a), .smm_b(smm_b), .smm_load(smm_load),
        .smm_sel(smm_sel), .smm_c(smm_c), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data));

    int checks = 0, errors = 0, cyc = 0, pops = 0;

    typedef struct { logic [IDW-1:0] id; logic [BW-1:0] data; } rsp_t;
    rsp_t expq[$];

    task automatic chk(string nm, logic [BW+31:0] act, logic [BW+31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack4(int d3, int d2, int d1, int d0);
        return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    // Reference: textbook C = A*B; partial mode keeps only C01 and C10.
    function automatic logic [BW-1:0] ref_mm(logic [BW-1:0] a, logic [BW-1:0] b, logic mode);
        logic [DW-1:0] ma[2][2], mb[2][2], mc[2][2];
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 2; k++) begin
                ma[i][k] = a[blk_lsb(i*2+k, DW) +: DW];
                mb[i][k] = b[blk_lsb(i*2+k, DW) +: DW];
            end
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 2; k++)
                mc[i][k] = ma[i][0]*mb[0][k] + ma[i][1]*mb[1][k];
        if (mode == MODE_FULL) return {mc[1][1], mc[1][0], mc[0][1], mc[0][0]};
        return {mc[0][1], {DW{1'b0}}, mc[1][0], {DW{1'b0}}};
    endfunction

    // Shared unit: products captured on load, C_out one edge later using sel at that edge.
    logic [BW-1:0] s1, cq;
    assign smm_c = cq;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            s1 <= '0;
            cq <= '0;
        end else begin
            if (smm_load) s1 <= ref_mm(smm_a, smm_b, 1'b0);
            cq <= smm_sel ? {s1[DW +: DW], {DW{1'b0}}, s1[2*DW +: DW], {DW{1'b0}}} : s1;
        end
    end

    // Issue checker: round-robin winner, mode match and credit rule from the bench's own bookkeeping.
    int  outst = 0, rr_m = 0, ew;
    logic have, ex_iss, ld_d1 = 0, ld_d2 = 0, sel_prev = 0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            expq.delete();
            outst = 0; rr_m = 0; ld_d1 = 0; ld_d2 = 0; sel_prev = 0;
        end else begin
            have = 0; ew = 0;
            for (int i = 0; i < NREQ; i++)
                if (!have && req_valid[(rr_m+i) % NREQ]) begin
                    have = 1; ew = (rr_m+i) % NREQ;
                end
            ex_iss = have && (req_mode[ew] == smm_sel) && (outst < RSP_DEPTH);
            chk("req_ready", req_ready, ex_iss ? (1 << ew) : 0);
            chk("smm_load", smm_load, ex_iss);
            if (smm_sel != sel_prev) chk("sel_change_with_job_in_flight", ld_d1 | ld_d2, 0);
            if (ex_iss && smm_load) begin
                chk("smm_a", smm_a, req_a[ew*BW +: BW]);
                chk("smm_b", smm_b, req_b[ew*BW +: BW]);
                expq.push_back('{id: IDW'(ew), data: ref_mm(req_a[ew*BW +: BW], req_b[ew*BW +: BW], req_mode[ew])});
                rr_m = (ew + 1) % NREQ;
                outst++;
            end
            if (rsp_valid && rsp_ready) outst--;
            ld_d2 = ld_d1; ld_d1 = smm_load; sel_prev = smm_sel;
        end
    end

    // Response monitor: pops the scoreboard whenever a response is consumed.
    rsp_t e;
    initial forever begin
        @(negedge clk);
        if (!rst && rsp_valid && rsp_ready) begin
            pops++;
            if (expq.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected got id=%0d want none", rsp_id);
            end else begin
                e = expq.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic job(int r, logic m, logic [BW-1:0] a, logic [BW-1:0] b);
        req_valid[r] = 1'b1; req_mode[r] = m;
        req_a[r*BW +: BW] = a; req_b[r*BW +: BW] = b;
    endtask

    task automatic idle(int n);
        req_valid = '0;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Waits for the next smm_load or rsp_valid (sel: 0/1), bounded; returns cycle number or -1.
    task automatic wait_for(int sel, int budget, output int at);
        at = -1;
        for (int k = 0; k < budget && at < 0; k++) begin
            @(negedge clk);
            if ((sel == 0 && smm_load) || (sel == 1 && rsp_valid)) at = cyc;
        end
    endtask

    task automatic rand_cycle(int pct);
        logic [NREQ-1:0] rdy;
        @(negedge clk); rdy = req_ready;
        tick();
        for (int r = 0; r < NREQ; r++)
            if (rdy[r] || !req_valid[r]) begin
                req_valid[r] = ($urandom_range(99) < pct);
                req_mode[r]  = 1'($urandom_range(1));
                req_a[r*BW +: BW] = {$urandom, $urandom, $urandom, $urandom};
                req_b[r*BW +: BW] = {$urandom, $urandom, $urandom, $urandom};
            end
        rsp_ready = ($urandom_range(3) != 0);
    endtask

    logic [BW-1:0] A, B;
    int t0, t1, n, bad, last_id, seen;
    initial begin
        A = pack4(4, 3, 2, 1);
        B = pack4(8, 7, 6, 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_sel", smm_sel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", {rsp_id, rsp_data}, 0);
        chk("rst_smm_a", smm_a, 0);
        tick(); rst = 1'b0;

        // Single full-mode job from requester 0.
        tick(); job(0, MODE_FULL, A, B);
        @(negedge clk); chk("t1_load", smm_load, 1); t0 = cyc;
        tick(); req_valid = '0;
        wait_for(1, 10, t1);
        chk("t1_latency", t1 - t0, 3);
        chk("t1_id", rsp_id, 0);
        chk("t1_data", rsp_data, pack4(50, 43, 22, 19));

        // Partial-mode job from requester 1 forces a mode switch first.
        tick(); job(1, MODE_PART, A, B);
        @(negedge clk); chk("t2_switch_noload", smm_load, 0);
        @(negedge clk); chk("t2_load", smm_load, 1); chk("t2_sel", smm_sel, 1); t0 = cyc;
        tick(); req_valid = '0;
        wait_for(1, 10, t1);
        chk("t2_latency", t1 - t0, 3);
        chk("t2_id", rsp_id, 1);
        chk("t2_data", rsp_data, pack4(22, 0, 43, 0));
        idle(4);

        // Both requesters streaming full mode: one switch cycle, then alternate every cycle.
        job(0, MODE_FULL, A, B); job(1, MODE_FULL, B, A);
        n = 0; bad = 0; last_id = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (smm_load) begin
                n++;
                if (int'(req_ready[1]) == last_id) bad++;
                last_id = int'(req_ready[1]);
            end
        end
        chk("t3_loads", n, 11);
        chk("t3_alternate", bad, 0);
        tick(); idle(6);

        // Full job then partial job: the switch must wait for the first job to clear.
        job(0, MODE_FULL, A, B);
        @(negedge clk); chk("t4_load0", smm_load, 1); t0 = cyc;
        tick(); req_valid[0] = 1'b0; job(1, MODE_PART, B, A);
        wait_for(0, 8, t1);
        chk("t4_gap", t1 - t0, 3);
        tick(); idle(6);

        // Stalled consumer: credits cap issue at RSP_DEPTH, then drain and resume.
        rsp_ready = 1'b0;
        job(0, MODE_PART, A, B); job(1, MODE_PART, B, A);
        n = 0;
        for (int k = 0; k < 12; k++) begin @(negedge clk); if (smm_load) n++; end
        chk("t5_issues_capped", n, RSP_DEPTH);
        chk("t5_ready_low", req_ready, 0);
        tick(); rsp_ready = 1'b1;
        n = 0; seen = pops;
        for (int k = 0; k < 12; k++) begin @(negedge clk); if (smm_load) n++; end
        chk("t5_resumed", n > 0, 1);
        chk("t5_drained", pops - seen >= RSP_DEPTH, 1);
        tick(); idle(8);
        chk("t5_scoreboard_empty", expq.size(), 0);

        // Randomised traffic with a randomly stalling consumer.
        for (int k = 0; k < 400; k++) rand_cycle(60);
        tick(); rsp_ready = 1'b1; idle(10);
        chk("rand_scoreboard_empty", expq.size(), 0);

        // Reset one cycle after an issue drops the job.
        job(0, smm_sel, A, B);
        @(negedge clk); chk("t6_load", smm_load, 1);
        tick(); req_valid = '0; rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_outputs", {req_ready, smm_load, smm_sel, rsp_valid, rsp_id}, 0);
        chk("t6_rst_data", rsp_data, 0);
        n = 0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (rsp_valid) n++; end
        chk("t6_no_response", n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
